dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port 256-word data memory. Port 0 serves the pipeline MEM stage; port 1 serves the program loader/debug port. It grants one access at a time, drives the memory's address, write-data, write-enable and read-enable lines, captures read data into per-port registers, and returns a one-cycle ack per completed access.

Parameters:
ADDR_W, 32, requester/memory address width (word address)
DATA_W, 32, data width
DEPTH, 256, number of valid memory words; addresses >= DEPTH are out of range

Ports:
clk  input  1  system clock; all state changes on posedge
rst  input  1  synchronous, active-high reset
req0  input  1  port 0 access request; held until ack0
we0  input  1  port 0: 1=write, 0=read
addr0  input  ADDR_W  port 0 word address
wdata0  input  DATA_W  port 0 write data
ack0  output  1  port 0 completion pulse (one cycle)
rdata0  output  DATA_W  port 0 registered read data
err0  output  1  port 0 out-of-range flag, valid with ack0
req1/we1/addr1/wdata1/ack1/rdata1/err1  same as port 0, for port 1
mem_addr  output  ADDR_W  to memory address input
mem_wdata  output  DATA_W  to memory write data
mem_we  output  1  to memory MemWrite
mem_re  output  1  to memory MemRead
mem_rdata  input  DATA_W  from memory read data (combinational)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, ack0/ack1=0, err0/err1=0, rdata0/rdata1=0, priority pointer=port 0, latched request fields=0. mem_we and mem_re are gated by !rst, so no memory write occurs on a reset edge even mid-access.
- FSM states: IDLE, SERVE.
- IDLE: eligible(n) = reqn && !ackn. If any port is eligible, latch that port's we/addr/wdata/id and go to SERVE. If both are eligible, the port named by the pointer wins. Otherwise stay in IDLE.
- SERVE (exactly one cycle):
  - Memory outputs are driven from the latched fields.
  - mem_re = !we_l && in_range; mem_we = we_l && in_range.
  - in_range = (addr_l < DEPTH). With the default parameters, this means addr_l[31:8]==0.
  - At the closing edge:
    - Write: the memory captures the write.
    - Read: rdata_id <= mem_rdata, or 0 if out of range.
    - Write: rdata_id holds its previous value.
    - ack_id <= 1; err_id <= !in_range.
    - Pointer <= other port.
  - Next state is IDLE.
- Outside SERVE: mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
- ackn and errn are high for exactly one cycle, then return to 0. rdatan holds until that port's next read completes.
- Latency: req seen in cycle T (IDLE) -> memory access in T+1 -> ackn and rdatan valid in T+2.
- Handshake rules:
  - A requester keeps req/we/addr/wdata stable until ack.
  - reqn is ignored in the cycle ackn=1, so a held req is not double-served.
  - A new request is accepted from the cycle after ack.
  - Peak throughput is one access per 2 cycles overall; one port alone completes one access every 3 cycles.
- Fairness: round-robin. After a grant to n, the other port wins the next tie. Neither port waits more than one foreign access.
- Out-of-range access: no memory strobe, ack still returned, err=1. A read returns rdata=0.
- Requester input changes during SERVE have no effect, because the fields are latched.

Test Plan:
- Single read: preload mem[1]=0x1, mem[2]=0xB; port 0 read addr 2 at T -> mem_re=1 and mem_addr=2 in T+1; ack0=1, rdata0=0x0000000B, err0=0 in T+2.
- Write then read: port 1 writes 0xDEADBEEF to addr 5, then reads addr 5 -> ack1 after each access; rdata1=0xDEADBEEF; mem_we high exactly one cycle.
- Contention: both ports request in the same cycle after reset -> port 0 served first, port 1 served next. Both hold req continuously -> grants alternate 0,1,0,1; no double service in ack cycles.
- Out of range: port 0 read addr 0x100 -> mem_re=0 throughout, ack0=1, err0=1, rdata0=0. Write to 0x12345 -> mem_we stays 0, err0=1.
- Reset mid-op: assert rst in the SERVE cycle of a write of 0x55 to addr 3 -> mem_we=0 that cycle, mem[3] unchanged, no ack. After reset, all outputs are 0 and state is IDLE.
- Idle: no req for 10 cycles -> mem_* outputs all 0; ack0/ack1 stay 0; rdata0/rdata1 hold their last values.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for the single-port data memory.
// One access per grant; each access takes one SERVE cycle and returns a one-cycle ack.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t state;
    logic ptr, id_l, we_l, el0, el1, grant, in_range, serve;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    // A port in its ack cycle is not eligible, so a held request is never served twice.
    assign el0 = req0 && !ack0;
    assign el1 = req1 && !ack1;
    assign grant = (el0 && el1) ? ptr : el1;
    assign in_range = 64'(addr_l) < 64'(DEPTH);
    // Strobes are gated by rst so a reset edge never commits a write.
    assign serve = (state == SERVE) && !rst;
    assign mem_addr = serve ? addr_l : '0;
    assign mem_wdata = serve ? wdata_l : '0;
    assign mem_we = serve && we_l && in_range;
    assign mem_re = serve && !we_l && in_range;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= 1'b0;
            id_l <= 1'b0;
            we_l <= 1'b0;
            addr_l <= '0;
            wdata_l <= '0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            if (state == IDLE) begin
                if (el0 || el1) begin
                    state <= SERVE;
                    id_l <= grant;
                    we_l <= grant ? we1 : we0;
                    addr_l <= grant ? addr1 : addr0;
                    wdata_l <= grant ? wdata1 : wdata0;
                end
            end else begin
                state <= IDLE;
                ptr <= !id_l;
                if (id_l) begin
                    ack1 <= 1'b1;
                    err1 <= !in_range;
                    if (!we_l) rdata1 <= in_range ? mem_rdata : '0;
                end else begin
                    ack0 <= 1'b1;
                    err0 <= !in_range;
                    if (!we_l) rdata0 <= in_range ? mem_rdata : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, hand sequences and a randomized transaction-level
// check of dmem_arbiter against a behavioural memory model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic ack0, err0, ack1, err1, mem_we, mem_re;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic tb_we = 1'b0;
    logic [7:0] tb_addr = '0;
    logic [31:0] tb_data = '0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    // Single-port memory: combinational read, write on posedge; the bench preloads via tb_we.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_re;
        logic        exp_we;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[11];

    logic        pend[2], pwe[2];
    logic [31:0] paddr[2], pdata[2], exp_rd[2];
    int          waitc[2], foreign[2];
    int          ack_seq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we = 1'b1;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic do_access(input vec_t v);
        drive(int'(v.port), 1'b1, v.we, v.addr, v.wdata);
        chk("idle_strobes", {mem_we, mem_re}, 2'b00);
        tick();
        chk("serve_re", mem_re, v.exp_re);
        chk("serve_we", mem_we, v.exp_we);
        chk("serve_addr", mem_addr, v.addr);
        chk("serve_noack", {ack0, ack1}, 2'b00);
        tick();
        chk("ack", {ack0, ack1}, v.port ? 2'b01 : 2'b10);
        chk("rdata", v.port ? rdata1 : rdata0, v.exp_rdata);
        chk("err", v.port ? err1 : err0, v.exp_err);
        chk("ack_strobes", {mem_we, mem_re}, 2'b00);
        drive(int'(v.port), 1'b0, 1'b0, '0, '0);
        tick();
        chk("ack_pulse", {ack0, ack1}, 2'b00);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk(name, {ack0, ack1, err0, err1, mem_we, mem_re}, 6'b0);
        chk({name, "_rdata"}, {rdata0, rdata1}, 64'h0);
        chk({name, "_mem"}, {mem_addr, mem_wdata}, 64'h0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h2,        32'h0,        1'b1, 1'b0, 32'hB,        1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h5,        32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h5,        32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h100,      32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'h12345,    32'h77,       1'b0, 1'b0, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h1,        32'h0,        1'b1, 1'b0, 32'h1,        1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'hFF,       32'h12,       1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'hFF,       32'h0,        1'b1, 1'b0, 32'h12,       1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'h4,        32'hA5,       1'b0, 1'b1, 32'h12,       1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h4,        32'h0,        1'b1, 1'b0, 32'hA5,       1'b0};

        for (int i = 0; i < 256; i++) poke(8'(i), 32'h0);
        poke(8'd1, 32'h1);
        poke(8'd2, 32'hB);
        poke(8'd3, 32'h33);
        tick();
        chk_zero_outputs("reset_state");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) do_access(vecs[i]);
        chk("mem_12345_untouched", mem[8'h45], 32'h0);

        rst = 1'b1;
        tick();
        chk_zero_outputs("reset_clears");
        rst = 1'b0;
        tick();

        // Simultaneous requests after reset: port 0 first, then port 1.
        drive(0, 1'b1, 1'b0, 32'h1, '0);
        drive(1, 1'b1, 1'b0, 32'h2, '0);
        tick();
        chk("tie_serve_addr", mem_addr, 32'h1);
        tick();
        chk("tie_first_ack", {ack0, ack1}, 2'b10);
        chk("tie_rdata0", rdata0, 32'h1);
        drive(0, 1'b0, 1'b0, '0, '0);
        tick();
        chk("tie_second_addr", mem_addr, 32'h2);
        tick();
        chk("tie_second_ack", {ack0, ack1}, 2'b01);
        chk("tie_rdata1", rdata1, 32'hB);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Both held continuously: grants must alternate with no double service.
        drive(0, 1'b1, 1'b0, 32'h1, '0);
        drive(1, 1'b1, 1'b0, 32'h2, '0);
        for (int c = 0; c < 16; c++) begin
            tick();
            chk("hold_no_dual_ack", ack0 && ack1, 1'b0);
            if (ack0) ack_seq.push_back(0);
            if (ack1) ack_seq.push_back(1);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        chk("hold_ack_count", ack_seq.size(), 8);
        foreach (ack_seq[i]) chk("hold_alternate", ack_seq[i], i % 2);
        tick();
        tick();

        // Reset landing on the SERVE cycle of a write must not commit it.
        drive(0, 1'b1, 1'b1, 32'h3, 32'h55);
        tick();
        rst = 1'b1;
        #1;
        chk("midreset_we", mem_we, 1'b0);
        tick();
        chk_zero_outputs("midreset_outputs");
        chk("midreset_mem3", mem[3], 32'h33);
        drive(0, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        tick();
        do_access('{1'b0, 1'b0, 32'h3, 32'h0, 1'b1, 1'b0, 32'h33, 1'b0});
        do_access('{1'b1, 1'b0, 32'h2, 32'h0, 1'b1, 1'b0, 32'hB, 1'b0});

        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_quiet", {ack0, ack1, mem_we, mem_re, mem_addr, mem_wdata}, 68'h0);
            chk("idle_hold", {rdata0, rdata1}, {32'h33, 32'hB});
        end

        // Randomized traffic checked at transaction level against ref_mem.
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        exp_rd[0] = 32'h33;
        exp_rd[1] = 32'hB;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; waitc[p] = 0; foreign[p] = 0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            chk("rand_invariant", !(ack0 && ack1) && !(mem_we && mem_re) &&
                !((mem_we || mem_re) && mem_addr >= 32'd256), 1'b1);
            for (int p = 0; p < 2; p++) begin
                logic a, e, inr;
                logic [31:0] rd;
                a = p ? ack1 : ack0;
                e = p ? err1 : err0;
                rd = p ? rdata1 : rdata0;
                if (a && !pend[p]) begin
                    chk("rand_spurious_ack", a, 1'b0);
                end else if (a) begin
                    inr = paddr[p] < 32'd256;
                    if (pwe[p] && inr) ref_mem[paddr[p][7:0]] = pdata[p];
                    if (!pwe[p]) exp_rd[p] = inr ? ref_mem[paddr[p][7:0]] : 32'h0;
                    chk("rand_err", e, !inr);
                    chk("rand_rdata", rd, exp_rd[p]);
                    chk("rand_fair", foreign[p] <= 1, 1'b1);
                    if (pend[1-p]) foreign[1-p]++;
                    pend[p] = 1'b0;
                    drive(p, 1'b0, 1'b0, '0, '0);
                end else if (pend[p]) begin
                    waitc[p]++;
                    if (waitc[p] > 8) begin
                        chk("rand_timeout", 1'b1, 1'b0);
                        pend[p] = 1'b0;
                        drive(p, 1'b0, 1'b0, '0, '0);
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && cyc < 1480 && $urandom_range(0, 2) != 0) begin
                    pwe[p] = 1'($urandom_range(0, 1));
                    paddr[p] = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h100) :
                               ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) :
                               32'($urandom_range(0, 255));
                    pdata[p] = $urandom;
                    pend[p] = 1'b1;
                    waitc[p] = 0;
                    foreign[p] = 0;
                    drive(p, 1'b1, pwe[p], paddr[p], pdata[p]);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
